// File: rtl/power_seq_ctrl.sv
// power_seq_ctrl: multi-domain power-gating sequencer.
// Each domain runs its own FSM and counter. The FSM walks isolation, retention
// and the power switch through an ordered sequence, and a level request starts it.
// The power-switch chain answers with an asynchronous ack. Each domain brings that
// ack into the clock domain through two flops. If the chain never answers, the
// domain parks in ERR until software clears it.
module power_seq_ctrl #(
    parameter int NUM_DOM  = 4,
    parameter int CNT_W    = 8,
    parameter int STEP_DLY = 4,
    parameter int ACK_TO   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DOM-1:0] req_off,
    input  logic [NUM_DOM-1:0] pse_ack,
    input  logic [NUM_DOM-1:0] clr_err,
    output logic [NUM_DOM-1:0] iso_en,
    output logic [NUM_DOM-1:0] ret_en,
    output logic [NUM_DOM-1:0] pse,
    output logic [NUM_DOM-1:0] dom_on,
    output logic [NUM_DOM-1:0] dom_off,
    output logic [NUM_DOM-1:0] err
);

    // State encoding. Legacy tools read these as plain constants.
    localparam logic [2:0] ST_ON      = 3'd0;
    localparam logic [2:0] ST_ISO_ON  = 3'd1;
    localparam logic [2:0] ST_RET_ON  = 3'd2;
    localparam logic [2:0] ST_PSW_OFF = 3'd3;
    localparam logic [2:0] ST_OFF     = 3'd4;
    localparam logic [2:0] ST_PSW_ON  = 3'd5;
    localparam logic [2:0] ST_RET_REL = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    // Timed states load STEP_LOAD on entry and count down to zero.
    // The exit happens on the edge that reads zero, so the dwell is exactly STEP_DLY cycles.
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_DLY - 1);
    // Ack waits count up from zero. The wait edge that reads ACK_LAST is the ACK_TO-th edge.
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TO - 1);
    localparam logic [CNT_W-1:0] ACK_SAT   = CNT_W'(ACK_TO);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       state_q [NUM_DOM];
    logic [2:0]       state_d [NUM_DOM];
    logic [CNT_W-1:0] cnt_q   [NUM_DOM];
    logic [CNT_W-1:0] cnt_d   [NUM_DOM];

    logic [NUM_DOM-1:0] ack_meta_q;
    logic [NUM_DOM-1:0] ack_s_q;

    logic [NUM_DOM-1:0] iso_en_q,  iso_en_d;
    logic [NUM_DOM-1:0] ret_en_q,  ret_en_d;
    logic [NUM_DOM-1:0] pse_q,     pse_d;
    logic [NUM_DOM-1:0] dom_on_q,  dom_on_d;
    logic [NUM_DOM-1:0] dom_off_q, dom_off_d;
    logic [NUM_DOM-1:0] err_q,     err_d;

    // Two-flop synchroniser for the switch-chain acks. Reset value is "powered".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta_q <= '1;
            ack_s_q    <= '1;
        end else begin
            ack_meta_q <= pse_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Per-domain next state and counter. Requests are sampled only in the stable states ON and OFF.
    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_ON: begin
                    if (req_off[i]) begin
                        state_d[i] = ST_ISO_ON;
                        cnt_d[i]   = STEP_LOAD;
                    end
                end
                ST_ISO_ON: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_RET_ON;
                        cnt_d[i]   = STEP_LOAD;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_RET_ON: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_PSW_OFF;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_PSW_OFF: begin
                    if (!ack_s_q[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= ACK_LAST) begin
                        state_d[i] = ST_ERR;
                        cnt_d[i]   = ACK_SAT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (!req_off[i]) begin
                        state_d[i] = ST_PSW_ON;
                        cnt_d[i]   = '0;
                    end
                end
                ST_PSW_ON: begin
                    if (ack_s_q[i]) begin
                        state_d[i] = ST_RET_REL;
                        cnt_d[i]   = STEP_LOAD;
                    end else if (cnt_q[i] >= ACK_LAST) begin
                        state_d[i] = ST_ERR;
                        cnt_d[i]   = ACK_SAT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_RET_REL: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_ERR: begin
                    if (clr_err[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_ON;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Moore output decode from the next state, so the registered outputs change on the entry edge.
    always_comb begin
        iso_en_d  = '0;
        ret_en_d  = '0;
        pse_d     = '0;
        dom_on_d  = '0;
        dom_off_d = '0;
        err_d     = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            case (state_d[i])
                ST_ON: begin
                    pse_d[i]    = 1'b1;
                    dom_on_d[i] = 1'b1;
                end
                ST_ISO_ON, ST_RET_REL: begin
                    iso_en_d[i] = 1'b1;
                    pse_d[i]    = 1'b1;
                end
                ST_RET_ON, ST_PSW_ON: begin
                    iso_en_d[i] = 1'b1;
                    ret_en_d[i] = 1'b1;
                    pse_d[i]    = 1'b1;
                end
                ST_PSW_OFF: begin
                    iso_en_d[i] = 1'b1;
                    ret_en_d[i] = 1'b1;
                end
                ST_OFF: begin
                    iso_en_d[i]  = 1'b1;
                    ret_en_d[i]  = 1'b1;
                    dom_off_d[i] = 1'b1;
                end
                ST_ERR: begin
                    iso_en_d[i] = 1'b1;
                    ret_en_d[i] = 1'b1;
                    err_d[i]    = 1'b1;
                end
                default: begin
                    pse_d[i]    = 1'b1;
                    dom_on_d[i] = 1'b1;
                end
            endcase
        end
    end

    // State and counter registers. Reset puts every domain in ON immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= ST_ON;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output registers. They are glitch-free drivers for the iso/ret/switch cells.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iso_en_q  <= '0;
            ret_en_q  <= '0;
            pse_q     <= '1;
            dom_on_q  <= '1;
            dom_off_q <= '0;
            err_q     <= '0;
        end else begin
            iso_en_q  <= iso_en_d;
            ret_en_q  <= ret_en_d;
            pse_q     <= pse_d;
            dom_on_q  <= dom_on_d;
            dom_off_q <= dom_off_d;
            err_q     <= err_d;
        end
    end

    assign iso_en  = iso_en_q;
    assign ret_en  = ret_en_q;
    assign pse     = pse_q;
    assign dom_on  = dom_on_q;
    assign dom_off = dom_off_q;
    assign err     = err_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// tb_power_seq_ctrl: directed bench for the multi-domain power sequencer.
// The bench works with NUM_DOM=4, STEP_DLY=4 and ACK_TO=16. Every expected value below is
// counted by hand from the edge on which the stimulus was applied.
module tb_power_seq_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req_off;
    logic [3:0] pse_ack;
    logic [3:0] clr_err;
    logic [3:0] iso_en;
    logic [3:0] ret_en;
    logic [3:0] pse;
    logic [3:0] dom_on;
    logic [3:0] dom_off;
    logic [3:0] err;

    int checks;
    int errors;

    power_seq_ctrl #(
        .NUM_DOM  (4),
        .CNT_W    (8),
        .STEP_DLY (4),
        .ACK_TO   (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_off (req_off),
        .pse_ack (pse_ack),
        .clr_err (clr_err),
        .iso_en  (iso_en),
        .ret_en  (ret_en),
        .pse     (pse),
        .dom_on  (dom_on),
        .dom_off (dom_off),
        .err     (err)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (iso_en  !== 4'b0000) begin errors++; $display("[TB] FAIL reset_iso: observed %b, expected 0000", iso_en); end
        checks++; if (ret_en  !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ret: observed %b, expected 0000", ret_en); end
        checks++; if (pse     !== 4'b1111) begin errors++; $display("[TB] FAIL reset_pse: observed %b, expected 1111", pse); end
        checks++; if (dom_on  !== 4'b1111) begin errors++; $display("[TB] FAIL reset_on: observed %b, expected 1111", dom_on); end
        checks++; if (dom_off !== 4'b0000) begin errors++; $display("[TB] FAIL reset_off: observed %b, expected 0000", dom_off); end
        checks++; if (err     !== 4'b0000) begin errors++; $display("[TB] FAIL reset_err: observed %b, expected 0000", err); end
    endtask

    // Domain 0 powers down. The request lands at edge k; the ack drops before edge m = k+9.
    task automatic test_power_down;
        req_off[0] = 1'b1;
        tick(1);
        checks++; if ({iso_en[0], ret_en[0], pse[0], dom_on[0]} !== 4'b1010) begin errors++; $display("[TB] FAIL pd_iso_k: observed %b, expected 1010", {iso_en[0], ret_en[0], pse[0], dom_on[0]}); end
        tick(3);
        checks++; if (ret_en[0] !== 1'b0) begin errors++; $display("[TB] FAIL pd_ret_k3: observed %b, expected 0", ret_en[0]); end
        tick(1);
        checks++; if ({iso_en[0], ret_en[0], pse[0]} !== 3'b111) begin errors++; $display("[TB] FAIL pd_ret_k4: observed %b, expected 111", {iso_en[0], ret_en[0], pse[0]}); end
        tick(3);
        checks++; if (pse[0] !== 1'b1) begin errors++; $display("[TB] FAIL pd_pse_k7: observed %b, expected 1", pse[0]); end
        tick(1);
        checks++; if ({iso_en[0], ret_en[0], pse[0]} !== 3'b110) begin errors++; $display("[TB] FAIL pd_pse_k8: observed %b, expected 110", {iso_en[0], ret_en[0], pse[0]}); end
        pse_ack[0] = 1'b0;
        tick(2);
        checks++; if (dom_off[0] !== 1'b0) begin errors++; $display("[TB] FAIL pd_off_m1: observed %b, expected 0", dom_off[0]); end
        tick(1);
        checks++; if ({dom_off[0], err[0], dom_on[0]} !== 3'b100) begin errors++; $display("[TB] FAIL pd_off_m2: observed %b, expected 100", {dom_off[0], err[0], dom_on[0]}); end
    endtask

    // Domain 0 powers back up from OFF. The ack rises two edges after the switch turns on.
    task automatic test_power_up;
        req_off[0] = 1'b0;
        tick(1);
        checks++; if ({iso_en[0], ret_en[0], pse[0], dom_off[0]} !== 4'b1110) begin errors++; $display("[TB] FAIL pu_pse_k: observed %b, expected 1110", {iso_en[0], ret_en[0], pse[0], dom_off[0]}); end
        tick(2);
        pse_ack[0] = 1'b1;
        tick(2);
        checks++; if (ret_en[0] !== 1'b1) begin errors++; $display("[TB] FAIL pu_ret_m1: observed %b, expected 1", ret_en[0]); end
        tick(1);
        checks++; if ({iso_en[0], ret_en[0], pse[0]} !== 3'b101) begin errors++; $display("[TB] FAIL pu_ret_m2: observed %b, expected 101", {iso_en[0], ret_en[0], pse[0]}); end
        tick(3);
        checks++; if ({iso_en[0], dom_on[0]} !== 2'b10) begin errors++; $display("[TB] FAIL pu_iso_m5: observed %b, expected 10", {iso_en[0], dom_on[0]}); end
        tick(1);
        checks++; if ({iso_en[0], ret_en[0], pse[0], dom_on[0]} !== 4'b0011) begin errors++; $display("[TB] FAIL pu_on_m6: observed %b, expected 0011", {iso_en[0], ret_en[0], pse[0], dom_on[0]}); end
    endtask

    // An asynchronous reset in the middle of RET_ON takes effect with no clock edge.
    task automatic test_reset_mid_seq;
        req_off[0] = 1'b1;
        tick(6);
        checks++; if (ret_en[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ret: observed %b, expected 1", ret_en[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({iso_en[0], ret_en[0], pse[0], dom_on[0]} !== 4'b0011) begin errors++; $display("[TB] FAIL mid_async: observed %b, expected 0011", {iso_en[0], ret_en[0], pse[0], dom_on[0]}); end
        req_off[0] = 1'b0;
        #2 rst = 1'b0;
        tick(2);
        checks++; if (dom_on !== 4'b1111) begin errors++; $display("[TB] FAIL mid_after: observed %b, expected 1111", dom_on); end
    endtask

    // A clr_err pulse outside ERR has no effect.
    task automatic test_clr_ignored;
        clr_err[0] = 1'b1;
        tick(1);
        clr_err[0] = 1'b0;
        tick(1);
        checks++; if ({dom_on[0], err[0], iso_en[0]} !== 3'b100) begin errors++; $display("[TB] FAIL clr_ignored: observed %b, expected 100", {dom_on[0], err[0], iso_en[0]}); end
    endtask

    // The ack reaches its target on the 16th wait edge. The ack wins and no error is raised.
    task automatic test_ack_on_deadline;
        req_off[0] = 1'b1;
        tick(9);
        checks++; if (pse[0] !== 1'b0) begin errors++; $display("[TB] FAIL dl_pse_fell: observed %b, expected 0", pse[0]); end
        tick(13);
        pse_ack[0] = 1'b0;
        tick(2);
        checks++; if ({dom_off[0], err[0]} !== 2'b00) begin errors++; $display("[TB] FAIL dl_p15: observed %b, expected 00", {dom_off[0], err[0]}); end
        tick(1);
        checks++; if ({dom_off[0], err[0]} !== 2'b10) begin errors++; $display("[TB] FAIL dl_p16: observed %b, expected 10", {dom_off[0], err[0]}); end
        tick(1);
        checks++; if ({dom_off[0], err[0]} !== 2'b10) begin errors++; $display("[TB] FAIL dl_p17: observed %b, expected 10", {dom_off[0], err[0]}); end
    endtask

    // The domain 1 ack stays high. The domain enters ERR exactly 16 edges after pse falls.
    task automatic test_ack_timeout;
        req_off[1] = 1'b1;
        tick(9);
        checks++; if (pse[1] !== 1'b0) begin errors++; $display("[TB] FAIL to_pse_fell: observed %b, expected 0", pse[1]); end
        tick(15);
        checks++; if ({err[1], dom_off[1]} !== 2'b00) begin errors++; $display("[TB] FAIL to_p15: observed %b, expected 00", {err[1], dom_off[1]}); end
        tick(1);
        checks++; if ({iso_en[1], ret_en[1], pse[1], err[1], dom_off[1]} !== 5'b11010) begin errors++; $display("[TB] FAIL to_p16: observed %b, expected 11010", {iso_en[1], ret_en[1], pse[1], err[1], dom_off[1]}); end
    endtask

    // Domains 2 and 3 start together while domain 1 sits in ERR. Domain 2 reverses its request during RET_ON.
    task automatic test_back_to_back;
        req_off[3:2] = 2'b11;
        tick(1);
        checks++; if ({iso_en[3:2], ret_en[3:2]} !== 4'b1100) begin errors++; $display("[TB] FAIL bb_iso_k: observed %b, expected 1100", {iso_en[3:2], ret_en[3:2]}); end
        tick(4);
        checks++; if ({ret_en[3:2], pse[3:2]} !== 4'b1111) begin errors++; $display("[TB] FAIL bb_ret_k4: observed %b, expected 1111", {ret_en[3:2], pse[3:2]}); end
        req_off[2] = 1'b0;
        tick(4);
        checks++; if ({pse[3:2], iso_en[3:2], dom_off[3:2]} !== 6'b001100) begin errors++; $display("[TB] FAIL bb_pse_k8: observed %b, expected 001100", {pse[3:2], iso_en[3:2], dom_off[3:2]}); end
        pse_ack[3:2] = 2'b00;
        tick(2);
        checks++; if (dom_off[3:2] !== 2'b00) begin errors++; $display("[TB] FAIL bb_off_m1: observed %b, expected 00", dom_off[3:2]); end
        tick(1);
        checks++; if ({dom_off[3:2], err[1]} !== 3'b111) begin errors++; $display("[TB] FAIL bb_off_m2: observed %b, expected 111", {dom_off[3:2], err[1]}); end
        pse_ack[2] = 1'b1;
        tick(1);
        checks++; if ({pse[2], dom_off[2], dom_off[3], pse[3]} !== 4'b1010) begin errors++; $display("[TB] FAIL bb_pswon_m3: observed %b, expected 1010", {pse[2], dom_off[2], dom_off[3], pse[3]}); end
        tick(5);
        checks++; if ({iso_en[2], dom_on[2]} !== 2'b10) begin errors++; $display("[TB] FAIL bb_rel_m8: observed %b, expected 10", {iso_en[2], dom_on[2]}); end
        tick(1);
        checks++; if ({iso_en[2], dom_on[2], err[1]} !== 3'b011) begin errors++; $display("[TB] FAIL bb_on_m9: observed %b, expected 011", {iso_en[2], dom_on[2], err[1]}); end
    endtask

    // clr_err moves domain 1 to OFF. Its request is already 0, so PSW_ON follows on the next edge.
    task automatic test_err_clear;
        req_off[1] = 1'b0;
        clr_err[1] = 1'b1;
        tick(1);
        clr_err[1] = 1'b0;
        checks++; if ({dom_off[1], err[1], pse[1]} !== 3'b100) begin errors++; $display("[TB] FAIL clr_off: observed %b, expected 100", {dom_off[1], err[1], pse[1]}); end
        tick(1);
        checks++; if ({dom_off[1], pse[1], ret_en[1]} !== 3'b011) begin errors++; $display("[TB] FAIL clr_pswon: observed %b, expected 011", {dom_off[1], pse[1], ret_en[1]}); end
        tick(5);
        checks++; if ({dom_on[1], iso_en[1], err[1]} !== 3'b100) begin errors++; $display("[TB] FAIL clr_on: observed %b, expected 100", {dom_on[1], iso_en[1], err[1]}); end
    endtask

    // Run the scenarios in sequence, then print the summary line.
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        req_off = 4'b0000;
        pse_ack = 4'b1111;
        clr_err = 4'b0000;
        #1;
        test_reset;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick(1);
        test_reset;
        test_power_down;
        test_power_up;
        test_reset_mid_seq;
        test_clr_ignored;
        test_ack_on_deadline;
        test_ack_timeout;
        test_back_to_back;
        test_err_clear;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
